// File: rtl/spi_reg_bridge.sv
// rtl/spi_reg_bridge.sv - SPI mode-0 slave exposing a small register file plus one read-only status byte
module spi_reg_bridge #(
  parameter  int NREGS       = 8,
  parameter  int SYNC_STAGES = 2,
  localparam int AW          = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sck_in,
  input  logic                 cs_n_in,
  input  logic                 mosi_in,
  output logic                 miso_out,
  output logic                 miso_oe,
  input  logic [7:0]           status_in,
  output logic [8*NREGS-9:0]   regs_out,
  output logic                 wr_strobe,
  output logic [AW-1:0]        wr_addr
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  localparam logic [AW-1:0] STATUS_ADDR = AW'(NREGS - 1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             tx_q, tx_d;
  logic                   tx_bit_q, tx_bit_d;
  logic                   rw_q, rw_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [7:0]             regs_q [NREGS-1];
  logic [7:0]             regs_d [NREGS-1];
  logic                   miso_q, miso_d;
  logic                   miso_oe_q, miso_oe_d;
  logic                   wr_strobe_q, wr_strobe_d;
  logic [AW-1:0]          wr_addr_q, wr_addr_d;
  logic [7:0]             rd_mux [NREGS];

  logic sck_s, cs_s, mosi_s, rise, fall;
  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign rise   = sck_s & ~sck_prev_q;
  assign fall   = ~sck_s & sck_prev_q;

  always_comb begin
    for (int k = 0; k < NREGS - 1; k++) rd_mux[k] = regs_q[k];
    rd_mux[NREGS-1] = status_in;
  end

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck_in};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n_in};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
    sck_prev_d  = sck_s;
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    tx_bit_d    = tx_bit_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    miso_oe_d   = ~cs_s;
    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        shift_d  = '0;
        tx_d     = '0;
        tx_bit_d = 1'b0;
        if (!cs_s) state_d = CMD;
      end
      CMD: begin
        if (cs_s) begin
          state_d = IDLE;
        end else if (rise) begin
          shift_d = {shift_q[6:0], mosi_s};
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            rw_d    = shift_d[7];
            addr_d  = shift_d[AW-1:0];
            state_d = DATA;
            if (shift_d[7]) tx_d = rd_mux[addr_d];
          end
        end
      end
      DATA: begin
        if (cs_s) begin
          state_d = IDLE;
        end else if (rise) begin
          shift_d = {shift_q[6:0], mosi_s};
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            state_d = DONE;
            if (!rw_q && addr_q != STATUS_ADDR) begin
              for (int k = 0; k < NREGS - 1; k++)
                if (addr_q == AW'(k)) regs_d[k] = shift_d;
              wr_strobe_d = 1'b1;
              wr_addr_d   = addr_q;
            end
          end
        end else if (fall && rw_q) begin
          // tx_bit stages the outgoing bit so MISO settles one cycle after the shift
          tx_bit_d = tx_q[7];
          tx_d     = {tx_q[6:0], 1'b0};
        end
      end
      default: begin
        if (cs_s) state_d = IDLE;
      end
    endcase
    miso_d = (state_q == DATA && rw_q) ? tx_bit_q : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      tx_bit_q    <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      for (int k = 0; k < NREGS - 1; k++) regs_q[k] <= '0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      tx_bit_q    <= tx_bit_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      regs_q      <= regs_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  for (genvar k = 0; k < NREGS - 1; k++) begin : g_regs_out
    assign regs_out[8*k +: 8] = regs_q[k];
  end

  assign miso_out  = miso_q;
  assign miso_oe   = miso_oe_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb/tb_spi_reg_bridge.sv - randomized self-checking bench for spi_reg_bridge against a register-map model
module tb_spi_reg_bridge;

  localparam int NREGS = 8;
  localparam int HALF  = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck_in = 1'b0;
  logic        cs_n_in = 1'b1;
  logic        mosi_in = 1'b0;
  logic        miso_out, miso_oe;
  logic [7:0]  status_in = 8'h00;
  logic [55:0] regs_out;
  logic        wr_strobe;
  logic [2:0]  wr_addr;

  spi_reg_bridge #(.NREGS(NREGS), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sck_in(sck_in), .cs_n_in(cs_n_in), .mosi_in(mosi_in),
    .miso_out(miso_out), .miso_oe(miso_oe), .status_in(status_in), .regs_out(regs_out),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         strobes = 0;
  logic [2:0] seen_addr = '0;
  logic [7:0] mregs [NREGS-1];
  int         exp_strobes = 0;
  logic [2:0] exp_addr = '0;
  logic       flip_status = 1'b0;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      strobes++;
      seen_addr = wr_addr;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sck_bit(input logic b, output logic m);
    mosi_in = b;
    wait_clk(HALF);
    m = miso_out;
    sck_in = 1'b1;
    wait_clk(HALF);
    sck_in = 1'b0;
  endtask

  task automatic frame(input logic [23:0] bits, input int nbits, output logic [7:0] rx);
    logic m;
    rx = '0;
    cs_n_in = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      sck_bit(bits[nbits-1-i], m);
      if (i >= 8 && i < 16) rx = {rx[6:0], m};
      if (i == 4) chk("miso_oe_active", miso_oe, 1'b1);
      if (flip_status && i == 11) status_in = ~status_in;
    end
    wait_clk(HALF);
    cs_n_in = 1'b1;
    wait_clk(2 * HALF);
    chk("miso_oe_idle", miso_oe, 1'b0);
  endtask

  task automatic check_state(input string tag);
    for (int k = 0; k < NREGS - 1; k++) chk($sformatf("%s_reg%0d", tag, k), regs_out[8*k +: 8], mregs[k]);
    chk($sformatf("%s_strobes", tag), strobes, exp_strobes);
    chk($sformatf("%s_wr_addr", tag), seen_addr, exp_addr);
  endtask

  // Full frame of nbits >= 16 whose leading 16 bits form the command; effect predicted from the register map
  task automatic model_frame(input string tag, input logic [23:0] bits, input int nbits);
    logic [15:0] fr;
    logic [7:0]  rx, exp_rd;
    logic [2:0]  a;
    fr = 16'(bits >> (nbits - 16));
    a  = fr[10:8];
    exp_rd = (a == 3'd7) ? status_in : mregs[a];
    frame(bits, nbits, rx);
    if (fr[15]) begin
      chk($sformatf("%s_rdata", tag), rx, exp_rd);
    end else if (a != 3'd7) begin
      mregs[a] = fr[7:0];
      exp_strobes++;
      exp_addr = a;
    end
    check_state(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk($sformatf("%s_regs", tag), regs_out, 56'h0);
    chk($sformatf("%s_miso", tag), miso_out, 1'b0);
    chk($sformatf("%s_oe", tag), miso_oe, 1'b0);
    chk($sformatf("%s_strobe", tag), wr_strobe, 1'b0);
    chk($sformatf("%s_waddr", tag), wr_addr, 3'd0);
  endtask

  initial begin
    logic [7:0]  rx;
    logic        m;
    logic [15:0] rf;
    for (int k = 0; k < NREGS - 1; k++) mregs[k] = 8'h00;
    wait_clk(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    wait_clk(5);

    model_frame("wr_a5", 24'h02A5, 16);
    model_frame("rd_a5", 24'h8200 | 24'($urandom_range(255)), 16);
    status_in = 8'h3C;
    model_frame("rd_status", 24'h8700, 16);
    model_frame("wr_status", 24'h0711, 16);

    flip_status = 1'b1;
    status_in = 8'h96;
    model_frame("status_hold", 24'h87FF, 16);
    flip_status = 1'b0;

    frame(24'h0155 >> 4, 12, rx);
    check_state("abort");
    model_frame("after_abort", 24'h0133, 16);
    model_frame("long_frame", 24'h0466FF, 24);

    for (int n = 0; n < 30; n++) begin
      rf = 16'($urandom);
      status_in = 8'($urandom);
      if ($urandom_range(5) == 0)
        model_frame($sformatf("rnd%0d", n), {rf, 8'($urandom)}, 24);
      else
        model_frame($sformatf("rnd%0d", n), {8'h00, rf}, 16);
    end

    cs_n_in = 1'b0;
    wait_clk(HALF);
    rf = 16'h03C3;
    for (int i = 0; i < 10; i++) sck_bit(rf[15-i], m);
    rst_n = 1'b0;
    wait_clk(2);
    check_reset_outputs("mid_reset");
    for (int k = 0; k < NREGS - 1; k++) mregs[k] = 8'h00;
    exp_addr = 3'd0;
    seen_addr = 3'd0;
    rst_n = 1'b1;
    for (int i = 10; i < 16; i++) sck_bit(rf[15-i], m);
    wait_clk(HALF);
    cs_n_in = 1'b1;
    wait_clk(2 * HALF);
    check_state("post_reset");
    model_frame("wr_after_reset", 24'h05E7, 16);
    model_frame("rd_after_reset", 24'h8500, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
